// File: rtl/sar_adc_scan.sv
// Multi-channel SAR ADC model: sanitise, sample, then resolve BITS bits MSB-first, one per clock.
// Latency: done and code appear BITS edges after the edge that accepts start.
// No backpressure: start is sampled only when idle; scan mode streams one result every BITS edges.
module sar_adc_scan #(
  parameter int  BITS     = 8,
  parameter int  CHANNELS = 4,
  parameter real VREF     = 1.0,
  parameter int  CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  real             vin [CHANNELS],
  input  logic            start,
  input  logic [CH_W-1:0] ch_sel,
  input  logic            scan,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] code,
  output logic [CH_W-1:0] code_ch,
  output logic            ovr
);

  localparam int  CNT_W = $clog2(BITS);
  localparam real LSB   = VREF / (2.0 ** BITS);

  typedef enum logic [0:0] {IDLE, CONVERT} state_t;

  state_t            state_q;
  real               sample_q;
  logic [BITS-1:0]   trial_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic              pend_q;
  logic              busy_q;
  logic              done_q;
  logic [BITS-1:0]   code_q;
  logic [CH_W-1:0]   code_ch_q;
  logic              ovr_q;

  // Capture path: channel to sample, its sanitised value and overrange flag
  logic [CH_W-1:0]   ch_next;
  logic [CH_W-1:0]   cap_ch_d;
  real               raw;
  logic [10:0]       raw_exp;
  real               sample_d;
  logic              pend_d;
  logic              start_ok;

  // Bit-resolution path
  logic [BITS-1:0]   bit_mask;
  logic              keep;
  logic [BITS-1:0]   trial_res;
  logic [BITS-1:0]   trial_d;

  // Select the channel to capture and clamp its value into [0, VREF]
  always_comb begin
    ch_next  = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
    cap_ch_d = (state_q == CONVERT) ? ch_next : ch_sel;
    start_ok = start && ({{(32-CH_W){1'b0}}, ch_sel} < 32'(CHANNELS));
    raw      = vin[cap_ch_d];
    // An all-ones exponent field marks NaN or +/-Inf.
    raw_exp  = 11'($realtobits(raw) >> 52);
    sample_d = raw;
    pend_d   = 1'b0;
    if (&raw_exp) begin
      sample_d = 0.0;
      pend_d   = 1'b1;
    end else if (raw < 0.0) begin
      sample_d = 0.0;
      pend_d   = 1'b1;
    end else if (raw > VREF) begin
      sample_d = VREF;
      pend_d   = 1'b1;
    end
  end

  // Decide the current bit and pre-set the next lower trial bit
  always_comb begin
    bit_mask  = {{(BITS-1){1'b0}}, 1'b1} << cnt_q;
    keep      = (sample_q >= real'(trial_q) * LSB);
    trial_res = keep ? trial_q : (trial_q & ~bit_mask);
    trial_d   = trial_res | (bit_mask >> 1);
  end

  // Conversion FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sample_q  <= 0.0;
      trial_q   <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      code_q    <= '0;
      code_ch_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            sample_q <= sample_d;
            ch_q     <= cap_ch_d;
            pend_q   <= pend_d;
            trial_q  <= {1'b1, {(BITS-1){1'b0}}};
            cnt_q    <= CNT_W'(BITS - 1);
            busy_q   <= 1'b1;
            state_q  <= CONVERT;
          end
        end
        CONVERT: begin
          if (cnt_q != '0) begin
            trial_q <= trial_d;
            cnt_q   <= cnt_q - 1'b1;
          end else begin
            code_q    <= trial_res;
            code_ch_q <= ch_q;
            ovr_q     <= pend_q;
            done_q    <= 1'b1;
            if (scan) begin
              // Back-to-back capture of the next channel keeps results gapless.
              sample_q <= sample_d;
              ch_q     <= cap_ch_d;
              pend_q   <= pend_d;
              trial_q  <= {1'b1, {(BITS-1){1'b0}}};
              cnt_q    <= CNT_W'(BITS - 1);
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign code    = code_q;
  assign code_ch = code_ch_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_sar_adc_scan.sv
// Bench for sar_adc_scan: directed vectors, expected results queued at issue time.
// A negedge monitor pops and compares on every done pulse, including the edge it arrives on.
// A 5-channel instance covers rejection of an out-of-range channel index.
module tb_sar_adc_scan;
  localparam int BITS = 8;

  typedef struct {
    logic [7:0] code;
    logic [1:0] ch;
    logic       ovr;
    int         edge_no;
  } exp_t;

  exp_t expq[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       scan = 1'b0;
  logic [1:0] ch_sel = 2'd0;
  real        vin [4];
  logic       busy, done, ovr;
  logic [7:0] code;
  logic [1:0] code_ch;

  logic       start2 = 1'b0;
  logic [2:0] ch_sel2 = 3'd0;
  real        vin2 [5];
  logic       busy2, done2, ovr2;
  logic [7:0] code2;
  logic [2:0] code_ch2;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int done2_cnt = 0;
  int k;

  sar_adc_scan #(.BITS(8), .CHANNELS(4), .VREF(1.0)) dut (
    .clk(clk), .rst(rst), .vin(vin), .start(start), .ch_sel(ch_sel), .scan(scan),
    .busy(busy), .done(done), .code(code), .code_ch(code_ch), .ovr(ovr)
  );

  sar_adc_scan #(.BITS(8), .CHANNELS(5), .VREF(1.0)) dut5 (
    .clk(clk), .rst(rst), .vin(vin2), .start(start2), .ch_sel(ch_sel2), .scan(1'b0),
    .busy(busy2), .done(done2), .code(code2), .code_ch(code_ch2), .ovr(ovr2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [7:0] c, input logic o, input int e_no);
    exp_t e;
    e.code = c; e.ch = ch; e.ovr = o; e.edge_no = e_no;
    expq.push_back(e);
  endtask

  // Start a single conversion on ch; it is accepted at the next edge.
  task automatic issue(input logic [1:0] ch, input logic [7:0] c, input logic o);
    push_exp(ch, c, o, cyc + 1 + BITS);
    ch_sel = ch;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done2) done2_cnt++;
    if (done) begin
      if (expq.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("code", code, e.code);
        check("code_ch", code_ch, e.ch);
        check("ovr", ovr, e.ovr);
        check("done_edge", cyc, e.edge_no);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (vin[i]) vin[i] = 0.0;
    foreach (vin2[i]) vin2[i] = 0.0;

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_code", code, 0);
    check("rst_code_ch", code_ch, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b1;
    tick();

    // 1: single shot, mid-scale
    vin[2] = 0.5;
    k = cyc + 1;
    issue(2'd2, 8'd128, 1'b0);
    wait_idle();
    check("s1_busy_fall_edge", cyc, k + 8);

    // 2: range handling on channel 0
    vin[0] = 1.0;   issue(2'd0, 8'd255, 1'b0); wait_idle();
    vin[0] = 1.5;   issue(2'd0, 8'd255, 1'b1); wait_idle();
    vin[0] = $bitstoreal(64'h7FF8000000000000); issue(2'd0, 8'd0, 1'b1); wait_idle();
    vin[0] = -0.2;  issue(2'd0, 8'd0, 1'b1); wait_idle();
    vin[0] = $bitstoreal(64'h7FF0000000000000); issue(2'd0, 8'd0, 1'b1); wait_idle();
    vin[0] = 0.0;   issue(2'd0, 8'd0, 1'b0); wait_idle();

    // 3: round-robin scan, scan dropped during the fifth conversion
    vin[0] = 0.1; vin[1] = 0.2; vin[2] = 0.3; vin[3] = 0.4;
    scan = 1'b1;
    k = cyc + 1;
    issue(2'd0, 8'd25, 1'b0);
    push_exp(2'd1, 8'd51,  1'b0, k + 16);
    push_exp(2'd2, 8'd76,  1'b0, k + 24);
    push_exp(2'd3, 8'd102, 1'b0, k + 32);
    push_exp(2'd0, 8'd25,  1'b0, k + 40);
    while (cyc < k + 33) tick();
    check("scan_busy_held", busy, 1);
    scan = 1'b0;
    wait_idle();
    check("scan_end_edge", cyc, k + 40);

    // 4: reset at edge 4 of a conversion aborts it
    vin[3] = 0.7;
    ch_sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_code", code, 0);
    rst = 1'b1;
    repeat (12) tick();
    check("abort_code_held", code, 0);

    // 5a: start during a conversion is ignored
    vin[1] = 0.6;
    k = cyc + 1;
    issue(2'd1, 8'd153, 1'b0);
    tick(); tick();
    ch_sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    check("ignored_start_done_edge", cyc, k + 8);
    repeat (10) tick();

    // 5b: out-of-range channel on the 5-channel instance
    vin2[4] = 0.75;
    ch_sel2 = 3'd5;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("badch_busy", busy2, 0);
    repeat (12) tick();
    check("badch_no_done", done2_cnt, 0);
    ch_sel2 = 3'd4;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("ch4_busy", busy2, 1);
    for (int n = 0; n < 40 && busy2; n++) tick();
    tick();
    check("ch4_done_count", done2_cnt, 1);
    check("ch4_code", code2, 192);
    check("ch4_code_ch", code_ch2, 4);
    check("ch4_ovr", ovr2, 0);

    // 6: input change after capture has no effect
    vin[1] = 0.25;
    issue(2'd1, 8'd64, 1'b0);
    tick();
    vin[1] = 0.9;
    wait_idle();
    check("hold_code_after_done", code, 64);

    repeat (4) tick();
    check("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
